// File: rtl/stack_unit.sv
// Operand stack for the stack-machine datapath: push/pop strobes from the
// controller, zero-latency top-of-stack, occupancy/full/empty status and
// sticky overflow/underflow error flags.
module stack_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              clear_err,
    output logic [WIDTH-1:0]  tos,
    output logic [AW:0]       count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    top_idx;
    logic             is_empty;
    logic             is_full;

    assign is_empty = (count_q == CW'(0));
    assign is_full  = (count_q == CW'(DEPTH));
    assign top_idx  = AW'(count_q - CW'(1));

    // Next-state for occupancy, flags and the memory write port.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        we      = 1'b0;
        waddr   = AW'(count_q);
        unique case ({push, pop})
            2'b10: begin
                if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    we      = 1'b1;
                    waddr   = AW'(count_q);
                    count_d = count_q + CW'(1);
                end
            end
            2'b01: begin
                if (is_empty) begin
                    unf_d = 1'b1;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            2'b11: begin
                we = 1'b1;
                if (is_empty) begin
                    // Nothing to replace: behaves as a plain push, but the pop was bogus.
                    waddr   = AW'(0);
                    count_d = CW'(1);
                    unf_d   = 1'b1;
                end else begin
                    waddr = top_idx;
                end
            end
            default: ;
        endcase
        // Clear wins over a same-cycle error.
        if (clear_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
    end

    // Occupancy and sticky error flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage array; deliberately not reset, count alone defines validity.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= data_in;
        end
    end

    // Outputs: tos reads combinationally so it tracks count in the same cycle.
    assign tos       = is_empty ? '0 : mem[top_idx];
    assign count     = count_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit with hand-computed expectations.
module tb_stack_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic       pop;
    logic [7:0] data_in;
    logic       clear_err;
    logic [7:0] tos;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       underflow;

    int tests = 0;
    int fails = 0;
    logic [7:0] cap_a;
    logic [7:0] cap_b;

    stack_unit #(.WIDTH(8), .DEPTH(16), .AW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .data_in   (data_in),
        .clear_err (clear_err),
        .tos       (tos),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one operation for exactly one clock edge, sample 1 time unit later.
    task automatic op(input logic p, input logic q, input logic [7:0] d, input logic ce);
        push = p; pop = q; data_in = d; clear_err = ce;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; data_in = 8'h00; clear_err = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        #1;
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; push = 1'b0; pop = 1'b0; data_in = 8'h00; clear_err = 1'b0;
        #12;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_unf", 32'(underflow), 32'd0);
        chk("rst_tos", 32'(tos), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic push/pop
        op(1, 0, 8'h11, 0);
        op(1, 0, 8'h22, 0);
        op(1, 0, 8'h33, 0);
        chk("t1_tos", 32'(tos), 32'h33);
        chk("t1_count", 32'(count), 32'd3);
        chk("t1_empty", 32'(empty), 32'd0);
        op(0, 1, 8'h00, 0);
        chk("t1_pop_tos", 32'(tos), 32'h22);
        chk("t1_pop_count", 32'(count), 32'd2);

        // Fill to full, then overflow
        do_reset();
        chk("t2_rst_count", 32'(count), 32'd0);
        for (int i = 1; i <= 16; i++) op(1, 0, 8'(i), 0);
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_tos", 32'(tos), 32'd16);
        chk("t2_count", 32'(count), 32'd16);
        op(1, 0, 8'hFF, 0);
        chk("t2_ovf", 32'(overflow), 32'd1);
        chk("t2_ovf_count", 32'(count), 32'd16);
        chk("t2_ovf_tos", 32'(tos), 32'd16);
        op(0, 0, 8'h00, 0);
        chk("t2_ovf_sticky", 32'(overflow), 32'd1);
        op(0, 0, 8'h00, 1);
        chk("t2_clr", 32'(overflow), 32'd0);
        // Replace on a full stack: no overflow
        op(1, 1, 8'h5A, 0);
        chk("t4_full_rep_count", 32'(count), 32'd16);
        chk("t4_full_rep_tos", 32'(tos), 32'h5A);
        chk("t4_full_rep_ovf", 32'(overflow), 32'd0);
        op(0, 1, 8'h00, 0);
        chk("t4_full_rep_below", 32'(tos), 32'd15);

        // Underflow on empty
        do_reset();
        op(0, 1, 8'h00, 0);
        chk("t3_unf", 32'(underflow), 32'd1);
        chk("t3_count", 32'(count), 32'd0);
        chk("t3_tos", 32'(tos), 32'd0);
        op(1, 0, 8'h05, 0);
        chk("t3_push_tos", 32'(tos), 32'h05);
        chk("t3_unf_sticky", 32'(underflow), 32'd1);
        // clear_err beats a same-cycle underflow
        op(0, 1, 8'h00, 0);
        op(0, 1, 8'h00, 1);
        chk("clr_prio_unf", 32'(underflow), 32'd0);
        chk("clr_prio_count", 32'(count), 32'd0);

        // Replace top on [07,03]
        do_reset();
        op(1, 0, 8'h07, 0);
        op(1, 0, 8'h03, 0);
        op(1, 1, 8'h0A, 0);
        chk("t4_rep_count", 32'(count), 32'd2);
        chk("t4_rep_tos", 32'(tos), 32'h0A);
        chk("t4_rep_unf", 32'(underflow), 32'd0);
        op(0, 1, 8'h00, 0);
        chk("t4_rep_below", 32'(tos), 32'h07);
        // Replace on empty: acts as push, flags underflow
        do_reset();
        op(1, 1, 8'h21, 0);
        chk("t4_empty_rep_count", 32'(count), 32'd1);
        chk("t4_empty_rep_tos", 32'(tos), 32'h21);
        chk("t4_empty_rep_unf", 32'(underflow), 32'd1);

        // ADD sequence
        do_reset();
        op(1, 0, 8'h04, 0);
        op(1, 0, 8'h09, 0);
        cap_a = tos;
        op(0, 1, 8'h00, 0);
        cap_b = tos;
        op(0, 1, 8'h00, 0);
        chk("t5_cap_a", 32'(cap_a), 32'h09);
        chk("t5_cap_b", 32'(cap_b), 32'h04);
        chk("t5_mid_empty", 32'(empty), 32'd1);
        op(1, 0, 8'(cap_a + cap_b), 0);
        chk("t5_count", 32'(count), 32'd1);
        chk("t5_tos", 32'(tos), 32'h0D);
        chk("t5_unf", 32'(underflow), 32'd0);

        // Async reset mid-cycle with flags set and count=5
        do_reset();
        op(0, 1, 8'h00, 0);
        for (int i = 0; i < 5; i++) op(1, 0, 8'(8'h40 + i), 0);
        chk("t6_pre_count", 32'(count), 32'd5);
        chk("t6_pre_unf", 32'(underflow), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_unf", 32'(underflow), 32'd0);
        chk("t6_ovf", 32'(overflow), 32'd0);
        chk("t6_tos", 32'(tos), 32'd0);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_hold", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
